// File: rtl/alu_result_stage.sv
// alu_result_stage: 2-entry in-order result FIFO with condition code register updated on accepted pushes
module alu_result_stage (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [31:0] RZ_In,
  input  logic [4:0]  Dest_In,
  input  logic        WE_In,
  input  logic        CARRY_FLAG,
  input  logic        OVERFLOW_FLAG,
  input  logic        ZERO_FLAG,
  input  logic        NEGATIVE_FLAG,
  input  logic        INR_FLAG,
  input  logic        IFNR_FLAG,
  input  logic        NOP_FLAG,
  input  logic        Flush,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] RZ_Out,
  output logic [4:0]  Dest_Out,
  output logic        WE_Out,
  output logic [31:0] CCR_Out,
  output logic [1:0]  Occupancy
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t      state, nxt;
  logic [37:0] head, tail, din;
  logic [6:0]  ccr;
  logic        push, pop, load_head, load_tail, shift;
  assign din       = {RZ_In, Dest_In, WE_In};
  assign In_Ready  = state != FULL;
  assign Out_Valid = state != EMPTY;
  assign Occupancy = state;
  assign push      = In_Valid & In_Ready & ~Flush;
  assign pop       = Out_Valid & Out_Ready & ~Flush;
  assign {RZ_Out, Dest_Out, WE_Out} = Out_Valid ? head : '0;
  assign CCR_Out   = {25'd0, ccr};
  // next state and entry-move controls; a push+pop in ONE replaces the head
  always_comb begin
    nxt       = state;
    load_head = 1'b0;
    load_tail = 1'b0;
    shift     = 1'b0;
    if (Flush) nxt = EMPTY;
    else
      case (state)
        EMPTY: begin
          nxt       = push ? ONE : EMPTY;
          load_head = push;
        end
        ONE: begin
          nxt       = (push && !pop) ? FULL : (pop && !push) ? EMPTY : ONE;
          load_head = push && pop;
          load_tail = push && !pop;
        end
        FULL: begin
          nxt   = pop ? ONE : FULL;
          shift = pop;
        end
        default: nxt = EMPTY;
      endcase
  end
  // state register, entry storage and condition codes
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
      ccr   <= '0;
    end else begin
      state <= nxt;
      head  <= load_head ? din : shift ? tail : head;
      tail  <= load_tail ? din : tail;
      if (push)
        ccr <= NOP_FLAG ? {1'b1, ccr[5:0]}
                        : {1'b0, IFNR_FLAG, INR_FLAG, NEGATIVE_FLAG, ZERO_FLAG, OVERFLOW_FLAG, CARRY_FLAG};
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed scoreboard bench for the result FIFO and condition codes
module tb_alu_result_stage;
  logic        Clock = 1'b0, Reset_n = 1'b1;
  logic        In_Valid = 1'b0, In_Ready;
  logic [31:0] RZ_In = '0;
  logic [4:0]  Dest_In = '0;
  logic        WE_In = 1'b0;
  logic [6:0]  fl = '0;
  logic        Flush = 1'b0, Out_Valid, Out_Ready = 1'b0;
  logic [31:0] RZ_Out, CCR_Out;
  logic [4:0]  Dest_Out;
  logic        WE_Out;
  logic [1:0]  Occupancy;
  logic [37:0] q[$];
  logic [37:0] exp_head;
  int          checks = 0, errors = 0;

  alu_result_stage dut (
    .Clock(Clock), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .RZ_In(RZ_In), .Dest_In(Dest_In), .WE_In(WE_In),
    .CARRY_FLAG(fl[0]), .OVERFLOW_FLAG(fl[1]), .ZERO_FLAG(fl[2]), .NEGATIVE_FLAG(fl[3]),
    .INR_FLAG(fl[4]), .IFNR_FLAG(fl[5]), .NOP_FLAG(fl[6]),
    .Flush(Flush), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .RZ_Out(RZ_Out), .Dest_Out(Dest_Out), .WE_Out(WE_Out),
    .CCR_Out(CCR_Out), .Occupancy(Occupancy)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] rz, input logic [4:0] d, input logic we,
                       input logic [6:0] f, input logic ordy, input logic fls, input logic acc);
    In_Valid = v; RZ_In = rz; Dest_In = d; WE_In = we; fl = f; Out_Ready = ordy; Flush = fls;
    if (acc) q.push_back({rz, d, we});
    if (fls) q.delete();
  endtask

  task automatic adv();
    @(posedge Clock);
    #1;
  endtask

  // monitor: whenever the consumer takes the head, compare it with the oldest expected entry
  always @(negedge Clock)
    if (Reset_n && Out_Valid && Out_Ready && !Flush) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL head_unexpected: got %0h expected none", RZ_Out);
      end else begin
        exp_head = q.pop_front();
        chk("head", {26'd0, RZ_Out, Dest_Out, WE_Out}, {26'd0, exp_head});
      end
    end

  initial begin
    #3 Reset_n = 1'b0;
    adv(); adv();
    chk("rst_valid", Out_Valid, 0);
    chk("rst_ready", In_Ready, 1);
    chk("rst_occ", Occupancy, 0);
    chk("rst_ccr", CCR_Out, 0);
    chk("rst_rz", RZ_Out, 0);
    Reset_n = 1'b1;
    // single result, 1-cycle latency
    drive(1, 32'h5, 5'd3, 1, 7'h01, 1, 0, 1);
    adv();
    chk("lat_valid", Out_Valid, 1);
    chk("lat_rz", RZ_Out, 32'h5);
    chk("lat_dest", Dest_Out, 3);
    chk("lat_ccr", CCR_Out, 32'h01);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    adv();
    chk("lat_empty", Out_Valid, 0);
    chk("pop_ccr_hold", CCR_Out, 32'h01);
    // fill to FULL with back-pressure, third offer refused
    drive(1, 32'hA, 5'd1, 1, 0, 0, 0, 1);
    adv();
    chk("fill_occ1", Occupancy, 1);
    drive(1, 32'hB, 5'd2, 0, 0, 0, 0, 1);
    adv();
    chk("fill_occ2", Occupancy, 2);
    chk("full_ready", In_Ready, 0);
    chk("full_head", RZ_Out, 32'hA);
    drive(1, 32'hC, 5'd3, 1, 0, 0, 0, 0);
    adv();
    chk("full_hold_occ", Occupancy, 2);
    chk("full_hold_rz", RZ_Out, 32'hA);
    chk("full_ccr", CCR_Out, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    adv();
    chk("drain_occ1", Occupancy, 1);
    chk("drain_rz", RZ_Out, 32'hB);
    adv();
    chk("drain_empty_rz", RZ_Out, 0);
    chk("drain_empty_occ", Occupancy, 0);
    // push and pop on the same edge in ONE
    drive(1, 32'h1, 5'd4, 1, 0, 0, 0, 1);
    adv();
    chk("pp_occ1", Occupancy, 1);
    drive(1, 32'h2, 5'd5, 1, 0, 1, 0, 1);
    adv();
    chk("pp_occ", Occupancy, 1);
    chk("pp_rz", RZ_Out, 32'h2);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    adv();
    chk("pp_empty", Occupancy, 0);
    // condition codes with NOP hold
    drive(1, 32'h10, 5'd6, 1, 7'b0001010, 1, 0, 1);
    adv();
    chk("ccr_nzvc", CCR_Out, 32'h0A);
    drive(1, 32'h20, 5'd7, 1, 7'b1000001, 1, 0, 1);
    adv();
    chk("ccr_nop", CCR_Out, 32'h4A);
    drive(1, 32'h30, 5'd8, 0, 7'b0111000, 1, 0, 1);
    adv();
    chk("ccr_inr_ifnr", CCR_Out, 32'h38);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    adv();
    chk("ccr_empty", Occupancy, 0);
    // flush while FULL with a push offered
    drive(1, 32'h11, 5'd9, 1, 7'h01, 0, 0, 1);
    adv();
    drive(1, 32'h22, 5'd10, 1, 7'h04, 0, 0, 1);
    adv();
    chk("fl_occ2", Occupancy, 2);
    chk("fl_ccr_pre", CCR_Out, 32'h04);
    drive(1, 32'h33, 5'd11, 1, 7'h08, 1, 1, 0);
    adv();
    chk("fl_occ", Occupancy, 0);
    chk("fl_valid", Out_Valid, 0);
    chk("fl_ccr", CCR_Out, 32'h04);
    chk("fl_ready", In_Ready, 1);
    adv();
    chk("fl_held_occ", Occupancy, 0);
    chk("fl_held_ready", In_Ready, 1);
    chk("fl_held_ccr", CCR_Out, 32'h04);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    adv();
    // asynchronous reset while FULL
    drive(1, 32'h44, 5'd12, 1, 7'h02, 0, 0, 1);
    adv();
    drive(1, 32'h55, 5'd13, 0, 7'h02, 0, 0, 1);
    adv();
    chk("ar_occ2", Occupancy, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 Reset_n = 1'b0;
    q.delete();
    #1;
    chk("ar_occ", Occupancy, 0);
    chk("ar_valid", Out_Valid, 0);
    chk("ar_out", {RZ_Out, Dest_Out, WE_Out}, 0);
    chk("ar_ccr", CCR_Out, 0);
    chk("ar_ready", In_Ready, 1);
    @(negedge Clock);
    Reset_n = 1'b1;
    drive(1, 32'h66, 5'd14, 1, 0, 0, 0, 1);
    adv();
    chk("post_rst_occ", Occupancy, 1);
    chk("post_rst_rz", RZ_Out, 32'h66);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    adv();
    adv();
    chk("final_occ", Occupancy, 0);
    chk("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
